// File: rtl/flash_rd_pkg.sv
// Shared types and default sizing for the parallel-NOR flash byte reader.
package flash_rd_pkg;

  localparam int DEF_ADDR_W      = 23;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int DEF_LEN_W       = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_RY = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/flash_byte_reader.sv
// Streams a burst of bytes out of an asynchronous parallel flash, one byte
// outstanding at a time, presenting each on a valid/ready interface.
module flash_byte_reader
  import flash_rd_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int LEN_W       = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] FL_ADDR,
  input  logic [7:0]        FL_DQ,
  output logic              FL_CE_N,
  output logic              FL_OE_N,
  output logic              FL_WE_N,
  input  logic              FL_RY
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_wait;
  logic [LEN_W-1:0]    r_remaining;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_done;
  logic                r_busy;
  logic                w_accept;

  // The byte in PRESENT is consumed on any edge where both sides agree.
  assign w_accept = r_valid & out_ready;

  // Next-state decode; abort wins over everything except the DONE->IDLE step.
  always_comb begin
    // NOTE: default first, so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (byte_count == '0) ? ST_DONE : ST_WAIT_RY;
        end
      end
      ST_WAIT_RY: begin
        if (abort)      w_state_nxt = ST_DONE;
        else if (FL_RY) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (abort)              w_state_nxt = ST_DONE;
        else if (r_wait == '0)  w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (abort) begin
          w_state_nxt = ST_DONE;
        end else if (w_accept) begin
          w_state_nxt = (r_remaining == LEN_W'(1)) ? ST_DONE : ST_WAIT_RY;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus strobes registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == ST_PRESENT);
      r_ce_n  <= (w_state_nxt != ST_ACCESS);
      r_oe_n  <= (w_state_nxt != ST_ACCESS);
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Burst bookkeeping: address, remaining count, access-wait counter, captured byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_wait      <= '0;
      r_data      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && (byte_count != '0)) begin
            r_addr      <= start_addr;
            r_remaining <= byte_count;
          end
        end
        ST_WAIT_RY: begin
          if (!abort && FL_RY) r_wait <= CNT_LOAD;
        end
        ST_ACCESS: begin
          if (!abort) begin
            if (r_wait == '0) r_data <= FL_DQ;
            else              r_wait <= r_wait - 1'b1;
          end
        end
        ST_PRESENT: begin
          // A handshake coinciding with abort still counts as delivered.
          if (w_accept && (r_remaining > LEN_W'(1))) begin
            r_remaining <= r_remaining - 1'b1;
            r_addr      <= r_addr + 1'b1;  // wraps at the top of the address space
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign FL_ADDR   = r_addr;
  assign FL_CE_N   = r_ce_n;
  assign FL_OE_N   = r_oe_n;
  assign FL_WE_N   = 1'b1;

endmodule

// File: tb/tb_flash_byte_reader.sv
// Directed bench for flash_byte_reader with a behavioural flash array.
module tb_flash_byte_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [22:0] start_addr;
  logic [23:0] byte_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] FL_ADDR;
  logic [7:0]  FL_DQ;
  logic        FL_CE_N;
  logic        FL_OE_N;
  logic        FL_WE_N;
  logic        FL_RY;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  // Flash contents: byte = a[7:0] ^ a[15:8] ^ a[22:16] ^ 0x3C; bus idles at 0.
  assign FL_DQ = (!FL_CE_N && !FL_OE_N)
               ? (FL_ADDR[7:0] ^ FL_ADDR[15:8] ^ {1'b0, FL_ADDR[22:16]} ^ 8'h3C)
               : 8'h00;

  flash_byte_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .byte_count (byte_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .FL_ADDR    (FL_ADDR),
    .FL_DQ      (FL_DQ),
    .FL_CE_N    (FL_CE_N),
    .FL_OE_N    (FL_OE_N),
    .FL_WE_N    (FL_WE_N),
    .FL_RY      (FL_RY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Steps at least one cycle, then until out_valid or the budget runs out.
  // Reports cycles stepped, cycles with CE low and the address seen while CE was low.
  task automatic wait_valid(input int max_cycles, output int cyc, output int ce_cyc,
                            output logic [22:0] ce_addr);
    cyc = 0; ce_cyc = 0; ce_addr = '0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (!FL_CE_N) begin
        ce_cyc++;
        ce_addr = FL_ADDR;
      end
    end while (!out_valid && cyc < max_cycles);
  endtask

  task automatic kick(input logic [22:0] a, input logic [23:0] n);
    @(negedge clk);
    start_addr = a;
    byte_count = n;
    start      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    int          ce_cyc;
    logic [22:0] ce_addr;
    int          bad;
    logic [7:0]  held;

    reset_n = 1'b0; start = 1'b0; start_addr = '0; byte_count = '0;
    abort = 1'b0; out_ready = 1'b1; FL_RY = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", FL_ADDR, 0);
    check("rst_ce_oe_we", {FL_CE_N, FL_OE_N, FL_WE_N}, 3'b111);
    reset_n = 1'b1;
    @(negedge clk);

    // Three-byte burst from 0x100 with a consumer that is always ready.
    kick(23'h000100, 24'd3);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("b1_latency", cyc, 6);
    check("b1_ce_cycles", ce_cyc, 4);
    check("b1_ce_addr", ce_addr, 23'h000100);
    check("b1_data", out_data, 8'h3D);
    check("b1_busy", busy, 1);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("b2_period", cyc, 6);
    check("b2_ce_addr", ce_addr, 23'h000101);
    check("b2_data", out_data, 8'h3C);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("b3_period", cyc, 6);
    check("b3_data", out_data, 8'h3F);
    @(negedge clk);
    check("b_done_pulse", {done, busy, out_valid}, 3'b110);
    @(negedge clk);
    check("b_done_clear", {done, busy}, 2'b00);

    // Zero-length request finishes immediately without touching the flash.
    kick(23'h000040, 24'd0);
    @(negedge clk);
    start = 1'b0;
    check("z_done", {done, busy, FL_CE_N}, 3'b111);
    @(negedge clk);
    check("z_idle", {done, busy, FL_CE_N}, 3'b001);

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort", {done, busy}, 2'b00);

    // Two-byte burst across the top of the address space.
    kick(23'h7FFFFF, 24'd2);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("w1_ce_addr", ce_addr, 23'h7FFFFF);
    check("w1_data", out_data, 8'h43);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("w2_ce_addr", ce_addr, 23'h000000);
    check("w2_data", out_data, 8'h3C);
    @(negedge clk);
    check("w_done", done, 1);
    @(negedge clk);

    // Back-pressure for 10 cycles, then flash busy for 5 cycles.
    out_ready = 1'b0;
    kick(23'h000200, 24'd2);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("bp_latency", cyc, 6);
    held = out_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || !FL_CE_N || !FL_OE_N) bad++;
    end
    check("bp_hold_violations", bad, 0);
    check("bp_data", held, 8'h3E);
    out_ready = 1'b1;
    FL_RY     = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!FL_CE_N || out_valid || !busy) bad++;
    end
    check("ry_wait_violations", bad, 0);
    FL_RY = 1'b1;
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("ry_delay_total", cyc + 6, 11);
    check("ry_ce_cycles", ce_cyc, 4);
    check("ry_data", out_data, 8'h3F);
    @(negedge clk);
    check("ry_done", done, 1);
    @(negedge clk);

    // Abort during the flash access of byte 2 of 5, with a stray start.
    kick(23'h000300, 24'd5);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("ab_b1_data", out_data, 8'h3F);
    @(negedge clk);
    @(negedge clk);
    check("ab_in_access", FL_CE_N, 0);
    abort      = 1'b1;
    start      = 1'b1;
    start_addr = 23'h000500;
    byte_count = 24'd4;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("ab_done", {done, out_valid, FL_CE_N, FL_OE_N}, 4'b1011);
    @(negedge clk);
    check("ab_idle", {done, busy}, 2'b00);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || !FL_CE_N) bad++;
    end
    check("ab_start_ignored", bad, 0);

    // Reset asserted while a byte is being presented.
    out_ready = 1'b0;
    kick(23'h000100, 24'd3);
    wait_valid(40, cyc, ce_cyc, ce_addr);
    check("rp_present", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rp_async", {busy, done, out_valid, FL_CE_N, FL_OE_N}, 5'b00011);
    check("rp_async_data_addr", {1'b0, FL_ADDR, out_data}, 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("rp_no_done", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_byte_reader.md
FLASH_BYTE_READER -- requirements
Module: flash_byte_reader

Interface
REQ-001 Parameter ADDR_W, default 23, flash byte-address width.
REQ-002 Parameter WAIT_CYCLES, default 4, cycles CE_N/OE_N held low per byte read (>=1); 4 covers a 70 ns access at 50 MHz.
REQ-003 Parameter LEN_W, default 24, byte-count width.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 start_addr  input  ADDR_W  first flash byte address; sampled with start.
REQ-008 byte_count  input  LEN_W  number of bytes to stream; sampled with start.
REQ-009 abort  input  1  terminate the current burst.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at burst end, normal or aborted.
REQ-012 out_data  output  8  streamed byte to the JPEG decoder front end.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  consumer accepts the byte when out_valid and out_ready are both high.
REQ-015 FL_ADDR  output  ADDR_W  flash address.
REQ-016 FL_DQ  input  8  flash read data; read-only, the top level keeps the pad tristated.
REQ-017 FL_CE_N, FL_OE_N  output  1 each  chip enable and read enable, active-low.
REQ-018 FL_WE_N  output  1  tied to 1.
REQ-019 FL_RY  input  1  flash ready/busy; 1 means ready.

Function
REQ-020 FSM states: IDLE, WAIT_RY, ACCESS, PRESENT, DONE.
REQ-021 IDLE, start=1, byte_count!=0: latch start_addr and byte_count, go to WAIT_RY.
REQ-022 IDLE, start=1, byte_count=0: go to DONE; no flash access occurs.
REQ-023 WAIT_RY: go to ACCESS when FL_RY=1, loading the wait counter with WAIT_CYCLES-1; otherwise stay in WAIT_RY.
REQ-024 ACCESS: FL_CE_N=0 and FL_OE_N=0, FL_ADDR stable at the current address, counter decrements each cycle.
REQ-025 ACCESS, counter=0: register FL_DQ into out_data on that edge and go to PRESENT.
REQ-026 PRESENT: out_valid=1, FL_CE_N=FL_OE_N=1, and out_data held stable until the byte is accepted.
REQ-027 PRESENT, byte accepted, remaining=1: go to DONE.
REQ-028 PRESENT, byte accepted, remaining>1: decrement remaining, increment the address, go to WAIT_RY.
REQ-029 Address increment wraps from 2^ADDR_W-1 to 0.
REQ-030 No prefetch: at most one byte is outstanding.
REQ-031 Latency with FL_RY=1: first out_valid in cycle N+WAIT_CYCLES+2, where N is the start cycle.
REQ-032 Throughput with out_ready=1 and FL_RY=1: one byte every WAIT_CYCLES+2 cycles.
REQ-033 DONE: done=1 for one cycle, then go to IDLE.
REQ-034 abort in any non-IDLE state: go to DONE next cycle; deassert out_valid, FL_CE_N and FL_OE_N immediately; the pending byte is dropped.
REQ-035 abort and a handshake in the same cycle: the byte counts as accepted, then the block enters DONE.
REQ-036 start while busy: ignored.
REQ-037 abort in IDLE: ignored.
REQ-038 FL_CE_N, FL_OE_N, out_valid, done and busy are registered outputs, free of glitches.

Reset
REQ-039 When reset_n=0, the block SHALL go to IDLE with busy=0, done=0, out_valid=0, out_data=0, FL_ADDR=0, FL_CE_N=1, FL_OE_N=1 and counters=0.
REQ-040 Reset asserted mid-burst SHALL abandon the burst without a done pulse.

Structure
REQ-041 Package flash_rd_pkg SHALL hold the state enum, the default WAIT_CYCLES, ADDR_W and LEN_W.
REQ-042 The block SHALL be a single module with no sub-module; the wait counter is inline.

Verification
REQ-043 start_addr=0x000100, byte_count=3, out_ready=1, FL_RY=1 -> bytes from 0x100, 0x101, 0x102; first out_valid 6 cycles after start; done 1 cycle after the third handshake.
REQ-044 byte_count=0 -> done pulse 1 cycle after start; FL_CE_N never low.
REQ-045 start_addr=0x7FFFFF, byte_count=2 -> FL_ADDR 0x7FFFFF, then 0x000000.
REQ-046 out_ready held low 10 cycles in PRESENT -> out_data stable, no flash access; FL_RY low 5 cycles -> ACCESS delayed 5 cycles.
REQ-047 abort during ACCESS of byte 2 of 5 -> out_valid stays 0, done pulses next cycle, busy drops; start while busy has no effect.
REQ-048 reset_n low during PRESENT -> all outputs at reset values asynchronously; no done pulse.
